uart_div_display: RTL and testbench

Receive-side UART command processor with a 16-cycle hardware divider and a 6-digit multiplexed hex display driver. It decodes two 9600-baud command frames from the host: dividend, then divisor. It computes quotient and remainder, drives the result onto the seven-segment scanner, and streams three result bytes to an external UART transmitter. It sits between the board's RX pin, the on-board 7-segment display, and the shared transmitter block.

---
 rtl/uart_div_display_pkg.sv | 9 +
 rtl/div_ctrl.sv | 79 +++++++
 rtl/seg_scan.sv | 28 ++
 rtl/uart_rx_core.sv | 72 +++++++
 rtl/uart_div_display.sv | 30 +++
 tb/tb_uart_div_display.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/uart_div_display_pkg.sv
// uart_div_display_pkg: shared control states, command byte and hex glyph table
package uart_div_display_pkg;
  typedef enum logic [2:0] {WAIT_CMD1, GET_A, WAIT_CMD2, GET_B, DIVIDE, SEND_QH, SEND_QL, SEND_R} ctrl_state_e;
  localparam logic [7:0] CMD_CHAR = 8'h73;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: command FSM, 16-step restoring divider and three-byte result sender
module div_ctrl
  import uart_div_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_ready_o,
  output logic [23:0] y_o
);
  ctrl_state_e state_q, state_d;
  logic [7:0] a_q, b_q, r_q, r_nx, tx_data_q, tx_byte;
  logic [15:0] q_q, q_nx;
  logic [23:0] y_q;
  logic [3:0] cnt_q;
  logic [1:0] ph_q;
  logic [8:0] r_sh;
  logic sub_ok, sending, fire, sent, tx_ready_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= WAIT_CMD1;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_CMD1: state_d = (rx_valid_i && rx_data_i == CMD_CHAR) ? GET_A : WAIT_CMD1;
      GET_A:     state_d = rx_valid_i ? WAIT_CMD2 : GET_A;
      WAIT_CMD2: state_d = (rx_valid_i && rx_data_i == CMD_CHAR) ? GET_B : WAIT_CMD2;
      GET_B:     state_d = rx_valid_i ? DIVIDE : GET_B;
      DIVIDE:    state_d = (cnt_q == 4'd15) ? SEND_QH : DIVIDE;
      default:   if (sent) state_d = state_q == SEND_QH ? SEND_QL : state_q == SEND_QL ? SEND_R : WAIT_CMD1;
    endcase
  end
  always_comb begin
    r_sh = {r_q, q_q[15]};
    sub_ok = r_sh >= {1'b0, b_q};
    r_nx = sub_ok ? 8'(r_sh - {1'b0, b_q}) : r_sh[7:0];
    q_nx = {q_q[14:0], sub_ok};
    sending = state_q inside {SEND_QH, SEND_QL, SEND_R};
    fire = sending && ph_q == 2'd0 && !tx_busy_i;
    sent = sending && ph_q == 2'd2 && !tx_busy_i;
    tx_byte = state_q == SEND_QH ? y_q[23:16] : state_q == SEND_QL ? y_q[15:8] : y_q[7:0];
  end
  // ph_q tracks the per-byte handshake: 0 wait idle, 1 wait busy rise, 2 wait busy fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      q_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      ph_q <= '0;
      tx_data_q <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      tx_ready_q <= fire;
      if (fire) tx_data_q <= tx_byte;
      ph_q <= fire ? 2'd1 : (ph_q == 2'd1 && tx_busy_i) ? 2'd2 : sent ? 2'd0 : ph_q;
      if (state_q == GET_A && rx_valid_i) a_q <= rx_data_i;
      if (state_q == GET_B && rx_valid_i) begin
        b_q <= rx_data_i;
        q_q <= {8'h00, a_q};
        r_q <= '0;
        cnt_q <= '0;
      end
      if (state_q == DIVIDE) begin
        q_q <= q_nx;
        r_q <= r_nx;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == 4'd15) y_q <= (b_q == 8'h00) ? {16'hFFFF, a_q} : {q_nx, r_nx};
      end
    end
  assign tx_data_o = tx_data_q;
  assign tx_ready_o = tx_ready_q;
  assign y_o = y_q;
endmodule

// File: rtl/seg_scan.sv
// seg_scan: six-digit active-low multiplexed hex display scanner
module seg_scan
  import uart_div_display_pkg::*;
#(
  parameter int SCAN_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] y_i,
  output logic [6:0]  led_o,
  output logic [5:0]  dig_o
);
  localparam int CW = $clog2(SCAN_CYCLES);
  logic [CW-1:0] cnt_q;
  logic [2:0] idx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(SCAN_CYCLES - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 1'b1;
    end else cnt_q <= cnt_q + 1'b1;
  always_comb begin
    dig_o = ~(6'b000001 << idx_q);
    led_o = SEG_TABLE[y_i[{idx_q, 2'b00} +: 4]];
  end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop synchronised 8N1 receiver sampling each bit at its centre
module uart_rx_core #(
  parameter int BIT_CYCLES = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  rx_state_e state_q, state_d;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, rx_s;
  assign rx_s = sync_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = (sync_q[2] && !rx_s) ? START : IDLE;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d = bit_q + 1'b1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (cnt_q == FULL) begin
        state_d = IDLE;
        valid_d = rx_s;
        data_d = rx_s ? shift_q : data_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 3'b111;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  assign data_o = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/uart_div_display.sv
// uart_div_display: UART-fed 8-bit divider with hex display and result streaming
module uart_div_display #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int SCAN_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic [23:0] y_to_led,
  output logic [6:0]  led_out,
  output logic [5:0]  dig
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  uart_rx_core #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk(clk), .rst(rst), .rx_i(rx), .data_o(rx_data), .valid_o(rx_ready)
  );
  div_ctrl u_ctrl (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_ready), .tx_busy_i(tx_busy),
    .tx_data_o(tx_data), .tx_ready_o(tx_ready), .y_o(y_to_led)
  );
  seg_scan #(.SCAN_CYCLES(SCAN_CYCLES)) u_scan (
    .clk(clk), .rst(rst), .y_i(y_to_led), .led_o(led_out), .dig_o(dig)
  );
endmodule

// File: tb/tb_uart_div_display.sv
// tb_uart_div_display: scoreboard bench for receiver, divider, sender and scanner
module tb_uart_div_display;
  localparam int BIT = 16;
  localparam int SCAN = 8;
  logic clk = 1'b0, rst, rx = 1'b1, tx_busy = 1'b0;
  logic [7:0] rx_data, tx_data;
  logic rx_ready, tx_ready;
  logic [23:0] y_to_led;
  logic [6:0] led_out;
  logic [5:0] dig;
  int checks = 0, errors = 0, cyc = 0, last_rx_cyc = 0;
  logic [7:0] exp_rx[$], exp_tx[$];
  logic [23:0] exp_y[$];
  logic [23:0] y_prev = '0;

  uart_div_display #(.CLK_FREQ(1600), .BAUD(100), .SCAN_CYCLES(SCAN)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_ready(tx_ready),
    .y_to_led(y_to_led), .led_out(led_out), .dig(dig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output %h, expected none", name, got);
  endtask

  always @(negedge clk)
    if (!rst && rx_ready) begin
      last_rx_cyc = cyc;
      if (exp_rx.size() == 0) unexpected("rx_ready", {24'h0, rx_data});
      else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
    end

  always @(negedge clk)
    if (!rst && tx_ready) begin
      if (exp_tx.size() == 0) unexpected("tx_ready", {24'h0, tx_data});
      else chk("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
    end

  always @(negedge clk)
    if (rst) y_prev = '0;
    else if (y_to_led !== y_prev) begin
      y_prev = y_to_led;
      if (exp_y.size() == 0) unexpected("y_to_led", {8'h0, y_to_led});
      else begin
        chk("y_to_led", {8'h0, y_to_led}, {8'h0, exp_y.pop_front()});
        chk("y_latency", cyc - last_rx_cyc, 17);
      end
    end

  // transmitter model: raises busy on the cycle it sees tx_ready, holds it 20 cycles
  initial forever begin
    @(negedge clk);
    if (tx_ready) begin
      tx_busy = 1'b1;
      repeat (20) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: still running after 60000 cycles, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_y.size() != 0 || exp_rx.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL seq_timeout: %0d tx bytes pending, expected 0", exp_tx.size());
      exp_tx.delete();
      exp_y.delete();
      exp_rx.delete();
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [23:0] y, input int gap);
    exp_rx.push_back(8'h73);
    exp_rx.push_back(a);
    exp_rx.push_back(8'h73);
    exp_rx.push_back(b);
    exp_y.push_back(y);
    exp_tx.push_back(y[23:16]);
    exp_tx.push_back(y[15:8]);
    exp_tx.push_back(y[7:0]);
    send_byte(8'h73, 1'b1, gap);
    send_byte(a, 1'b1, gap);
    send_byte(8'h73, 1'b1, gap);
    send_byte(b, 1'b1, gap);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
    chk({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
    chk({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    chk({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h0);
    chk({tag, "_y_to_led"}, {8'h0, y_to_led}, 32'h0);
    chk({tag, "_dig"}, {26'h0, dig}, 32'h3E);
    chk({tag, "_led_out"}, {25'h0, led_out}, 32'h40);
  endtask

  task automatic scan_test();
    logic [23:0] yv;
    logic [5:0] prev, want;
    int n, idx;
    yv = 24'h000300;
    n = 0;
    prev = dig;
    while (dig === prev && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 12; k++) begin
      prev = dig;
      want = {prev[4:0], prev[5]};
      n = 0;
      while (dig === prev && n < 100) begin @(negedge clk); n++; end
      chk("scan_period", n, SCAN);
      chk("scan_dig", {26'h0, dig}, {26'h0, want});
      idx = 0;
      for (int i = 0; i < 6; i++) if (!want[i]) idx = i;
      chk("scan_led", {25'h0, led_out}, (yv[idx*4 +: 4] == 4'h3) ? 32'h30 : 32'h40);
    end
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("post_reset");

    run_seq(8'h03, 8'h01, 24'h000300, 2 * BIT);
    scan_test();
    run_seq(8'hFF, 8'h07, 24'h002403, 2 * BIT);
    run_seq(8'h2A, 8'h00, 24'hFFFF2A, 2 * BIT);

    send_byte(8'h55, 1'b0, 2 * BIT);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    exp_rx.push_back(8'h41);
    send_byte(8'h41, 1'b1, 2 * BIT);
    run_seq(8'hC8, 8'h0D, 24'h000F05, 2 * BIT);

    run_seq(8'h64, 8'h07, 24'h000E02, 0);

    b = 8'h73;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[3];
    repeat (BIT / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    run_seq(8'h09, 8'h02, 24'h000401, 2 * BIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
